// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter shared definitions.
// Arbiter state encoding and Avalon-ST TX field widths.
package eth_tx_arbiter_pkg;

  localparam int AVST_DATA_W  = 64;
  localparam int AVST_EMPTY_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_SOP,
    ARB_XFER,
    ARB_ABORT
  } arb_state_t;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// eth_rr_pick: combinational round-robin picker.
// req/last one-hot in; pick = first req after last (wrapping), valid = |req.
module eth_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick,
  output logic         valid
);

  int   lidx;
  int   idx;
  logic found;

  always_comb begin
    lidx = 0;
    for (int i = 0; i < N; i++)
      if (last[i]) lidx = i;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (lidx + k) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet round-robin arbiter onto one 10G MAC TX port.
// src_* per-source Avalon-ST in, avalon_st_tx_* to MAC, busy/err status.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk_156_25,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              src_req,
  output logic [N_CH-1:0]              src_gnt,
  input  logic [N_CH-1:0]              src_startofpacket,
  input  logic [N_CH-1:0]              src_valid,
  input  logic [N_CH-1:0]              src_endofpacket,
  input  logic [AVST_EMPTY_W*N_CH-1:0] src_empty,
  input  logic [AVST_DATA_W*N_CH-1:0]  src_data,
  input  logic [N_CH-1:0]              src_error,
  output logic [N_CH-1:0]              src_ready,
  input  logic                         avalon_st_tx_ready,
  output logic                         avalon_st_tx_startofpacket,
  output logic                         avalon_st_tx_valid,
  output logic                         avalon_st_tx_endofpacket,
  output logic [AVST_EMPTY_W-1:0]      avalon_st_tx_empty,
  output logic [AVST_DATA_W-1:0]       avalon_st_tx_data,
  output logic                         avalon_st_tx_error,
  output logic [1:0]                   avalon_st_pause_data,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         proto_err
);

  localparam int CW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_M =
    (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] TO_MAX = TO_M[CW-1:0];

  arb_state_t       state;
  logic [N_CH-1:0]  last_gnt;
  logic [N_CH-1:0]  pick;
  logic             pick_vld;
  logic [CW-1:0]    wd;
  int               g;
  logic             g_vld;
  logic             g_sop;
  logic             g_eop;
  logic             g_err;
  logic [AVST_DATA_W-1:0]  g_data;
  logic [AVST_EMPTY_W-1:0] g_empty;
  logic             muxing;
  logic             accept;
  logic             wd_hit;

  eth_rr_pick #(.N(N_CH)) u_pick (
    .req   (src_req),
    .last  (last_gnt),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    g = 0;
    for (int i = 0; i < N_CH; i++)
      if (src_gnt[i]) g = i;
    g_vld   = src_valid[g];
    g_sop   = src_startofpacket[g];
    g_eop   = src_endofpacket[g];
    g_err   = src_error[g];
    g_data  = src_data[AVST_DATA_W*g +: AVST_DATA_W];
    g_empty = src_empty[AVST_EMPTY_W*g +: AVST_EMPTY_W];
  end

  assign muxing = (state == ARB_WAIT_SOP) ||
                  (state == ARB_XFER);
  assign accept = muxing && g_vld && avalon_st_tx_ready;
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd == TO_MAX);
  assign busy   = (state != ARB_IDLE);
  assign avalon_st_pause_data = 2'b00;

  always_comb begin
    avalon_st_tx_valid         = 1'b0;
    avalon_st_tx_startofpacket = 1'b0;
    avalon_st_tx_endofpacket   = 1'b0;
    avalon_st_tx_error         = 1'b0;
    avalon_st_tx_data          = '0;
    avalon_st_tx_empty         = '0;
    src_ready                  = '0;
    unique case (1'b1)
      muxing: begin
        avalon_st_tx_valid         = g_vld;
        avalon_st_tx_startofpacket = g_vld & g_sop;
        avalon_st_tx_endofpacket   = g_vld & g_eop;
        avalon_st_tx_error         = g_vld & g_err;
        avalon_st_tx_data          = g_data;
        avalon_st_tx_empty         = g_empty;
        src_ready = src_gnt & {N_CH{avalon_st_tx_ready}};
      end
      (state == ARB_ABORT): begin
        avalon_st_tx_valid       = 1'b1;
        avalon_st_tx_endofpacket = 1'b1;
        avalon_st_tx_error       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      src_gnt     <= '0;
      last_gnt    <= {1'b1, {(N_CH-1){1'b0}}};
      wd          <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          wd <= '0;
          if (pick_vld) begin
            src_gnt <= pick;
            state   <= ARB_WAIT_SOP;
          end
        end
        ARB_WAIT_SOP, ARB_XFER: begin
          if (accept) begin
            wd <= '0;
            if ((state == ARB_WAIT_SOP) ? !g_sop : g_sop)
              proto_err <= 1'b1;
            if (g_eop) begin
              last_gnt <= src_gnt;
              src_gnt  <= '0;
              state    <= ARB_IDLE;
            end else begin
              state <= ARB_XFER;
            end
          end else if (wd_hit) begin
            // A stalled source still counts as served.
            timeout_err <= 1'b1;
            last_gnt    <= src_gnt;
            src_gnt     <= '0;
            wd          <= '0;
            state <= (state == ARB_XFER) ? ARB_ABORT
                                         : ARB_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ARB_ABORT: begin
          if (avalon_st_tx_ready) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
